// File: rtl/sqw_pkg.sv
// Shared constants and types for the multi-channel square-wave generator.
package sqw_pkg;

  localparam int DEF_CNT_W  = 16;
  localparam int DEF_PERIOD = 8;
  localparam int DEF_HIGH   = 4;
  localparam int MIN_PERIOD = 2;

  typedef struct packed {
    logic [DEF_CNT_W-1:0] period;
    logic [DEF_CNT_W-1:0] high;
  } ch_cfg_t;

  // Channel index width; a single channel still gets one address bit.
  function automatic int ch_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/multi_square_wave_gen_if.sv
// Single-cycle configuration write port with a one-cycle ack/err response.
interface multi_square_wave_gen_if #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 16
);
  import sqw_pkg::*;

  localparam int CH_W = ch_w(N_CH);

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_high;
  logic             cfg_ack;
  logic             cfg_err;

  modport master (
    output cfg_we, cfg_ch, cfg_period, cfg_high,
    input  cfg_ack, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_period, cfg_high,
    output cfg_ack, cfg_err
  );

endinterface

// File: rtl/sqw_channel.sv
// One PWM channel: free-running counter with active/pending config, pending
// copied to active only at a period wrap (or at once while disabled).
module sqw_channel #(
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = 8,
  parameter int DEF_HIGH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             wr_vld,
  input  logic [CNT_W-1:0] wr_period,
  input  logic [CNT_W-1:0] wr_high,
  output logic             out,
  output logic             period_start
);

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
  } cfg_t;

  localparam cfg_t DEF_CFG = {CNT_W'(DEF_PERIOD), CNT_W'(DEF_HIGH)};

  cfg_t             act_q, act_d;
  cfg_t             pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             ps_q, ps_d;
  logic             wrap;

  always_comb begin
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    cnt_d      = cnt_q;
    out_d      = 1'b0;
    ps_d       = 1'b0;
    wrap       = (cnt_q == act_q.period - CNT_W'(1));

    if (!en) begin
      if (pend_vld_q) begin
        act_d      = pend_q;
        pend_vld_d = 1'b0;
      end
      // Parked on the last count so the first enabled edge is a wrap.
      cnt_d = act_d.period - CNT_W'(1);
    end else begin
      if (wrap) begin
        cnt_d = '0;
        ps_d  = 1'b1;
        if (pend_vld_q) begin
          act_d = pend_q;
        end
        pend_vld_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      out_d = (cnt_d < act_d.high);
    end

    // A write landing on a wrap edge is kept for the following wrap.
    if (wr_vld) begin
      pend_d     = {wr_period, wr_high};
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_q      <= DEF_CFG;
      pend_q     <= DEF_CFG;
      pend_vld_q <= 1'b0;
      cnt_q      <= CNT_W'(DEF_PERIOD - 1);
      out_q      <= 1'b0;
      ps_q       <= 1'b0;
    end else begin
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      ps_q       <= ps_d;
    end
  end

  assign out          = out_q;
  assign period_start = ps_q;

endmodule

// File: rtl/multi_square_wave_gen.sv
// N-channel square-wave/PWM generator: decodes the config write port into
// per-channel pending updates and answers each write with ack or err next cycle.
module multi_square_wave_gen #(
  parameter int N_CH       = 2,
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = 8,
  parameter int DEF_HIGH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          en,
  multi_square_wave_gen_if.slave   cfg,
  output logic [N_CH-1:0]          out,
  output logic [N_CH-1:0]          period_start
);
  import sqw_pkg::*;

  localparam int CH_W = ch_w(N_CH);

  logic [CH_W:0]   ch_ext;
  logic            ch_ok;
  logic            period_ok;
  logic            wr_ok;
  logic            cfg_ack_q, cfg_ack_d;
  logic            cfg_err_q, cfg_err_d;
  logic [N_CH-1:0] wr_vld;

  always_comb begin
    // One extra bit so the range check also works for power-of-two N_CH.
    ch_ext    = {1'b0, cfg.cfg_ch};
    ch_ok     = (ch_ext < (CH_W + 1)'(N_CH));
    period_ok = (cfg.cfg_period >= CNT_W'(MIN_PERIOD));
    wr_ok     = ch_ok && period_ok;
    cfg_ack_d = cfg.cfg_we && wr_ok;
    cfg_err_d = cfg.cfg_we && !wr_ok;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_ack_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_ack_q <= cfg_ack_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg.cfg_ack = cfg_ack_q;
  assign cfg.cfg_err = cfg_err_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign wr_vld[i] = cfg.cfg_we && wr_ok && (cfg.cfg_ch == CH_W'(i));

    sqw_channel #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_HIGH   (DEF_HIGH)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .en           (en[i]),
      .wr_vld       (wr_vld[i]),
      .wr_period    (cfg.cfg_period),
      .wr_high      (cfg.cfg_high),
      .out          (out[i]),
      .period_start (period_start[i])
    );
  end

endmodule

// File: tb/tb_multi_square_wave_gen.sv
// Scoreboard bench: stimulus pushes the hand-derived per-cycle outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_multi_square_wave_gen;
  import sqw_pkg::*;

  localparam int N = 3;
  localparam int W = 16;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] en    = '0;
  logic [N-1:0] out;
  logic [N-1:0] ps;

  multi_square_wave_gen_if #(.N_CH(N), .CNT_W(W)) cfg_if ();

  multi_square_wave_gen #(
    .N_CH       (N),
    .CNT_W      (W),
    .DEF_PERIOD (8),
    .DEF_HIGH   (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .cfg          (cfg_if),
    .out          (out),
    .period_start (ps)
  );

  always #5 clk = ~clk;

  typedef logic [2*N+1:0] exp_t;
  exp_t  exp_q[$];
  string tag_q[$];
  string cur_tag = "reset";
  int    checks = 0;
  int    failures = 0;

  // Bench view of each channel: phase within its period and the waveform it should show.
  int   k[N];
  int   P[N];
  int   H[N];
  logic exp_ack = 1'b0;
  logic exp_err = 1'b0;

  always @(negedge clk) begin
    exp_t  e;
    exp_t  a;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {out, ps, cfg_if.cfg_ack, cfg_if.cfg_err};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s @%0t: got out=%b ps=%b ack=%b err=%b, want out=%b ps=%b ack=%b err=%b",
                 t, $time, a[2*N+1 -: N], a[N+1 -: N], a[1], a[0],
                 e[2*N+1 -: N], e[N+1 -: N], e[1], e[0]);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      k[i] = 0;
      P[i] = 8;
      H[i] = 4;
    end
  endtask

  task automatic step();
    logic [N-1:0] eo;
    logic [N-1:0] ep;
    eo = '0;
    ep = '0;
    for (int i = 0; i < N; i++) begin
      if (!reset || !en[i]) begin
        k[i] = 0;
      end else begin
        eo[i] = (k[i] < H[i]);
        ep[i] = (k[i] == 0);
        k[i]  = (k[i] + 1) % P[i];
      end
    end
    @(posedge clk);
    #1;
    exp_q.push_back({eo, ep, exp_ack, exp_err});
    tag_q.push_back(cur_tag);
    exp_ack = 1'b0;
    exp_err = 1'b0;
    cfg_if.cfg_we = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Steps until the next edge of channel ch is a wrap.
  task automatic run_to_wrap(input int ch);
    for (int g = 0; g < 64 && k[ch] != 0; g++) step();
  endtask

  task automatic write(input int ch, input int p, input int h, input bit ok);
    ch_cfg_t c;
    c.period          = W'(p);
    c.high            = W'(h);
    cfg_if.cfg_we     = 1'b1;
    cfg_if.cfg_ch     = 2'(ch);
    cfg_if.cfg_period = c.period;
    cfg_if.cfg_high   = c.high;
    if (ok) exp_ack = 1'b1;
    else    exp_err = 1'b1;
    step();
  endtask

  // Write placed one edge after a wrap so it cannot coincide with one.
  task automatic safe_write(input int ch, input int p, input int h);
    run_to_wrap(ch);
    step();
    write(ch, p, h, 1'b1);
  endtask

  initial begin
    cfg_if.cfg_we     = 1'b0;
    cfg_if.cfg_ch     = '0;
    cfg_if.cfg_period = '0;
    cfg_if.cfg_high   = '0;
    model_reset();
    #1 reset = 1'b0;

    cur_tag = "reset";
    run(2);

    reset = 1'b1;
    en = 3'b011;
    cur_tag = "defaults";
    run(16);

    cur_tag = "ch1_wr";
    run(3);
    write(1, 10, 3, 1'b1);
    run_to_wrap(1);
    P[1] = 10;
    H[1] = 3;
    cur_tag = "ch1_10_3";
    run(20);

    cur_tag = "reject";
    write(0, 1, 1, 1'b0);
    write(0, 0, 5, 1'b0);
    write(3, 10, 5, 1'b0);
    run(10);

    cur_tag = "ch2_dis";
    write(2, 4, 1, 1'b1);
    P[2] = 4;
    H[2] = 1;
    step();
    en[2] = 1'b1;
    cur_tag = "ch2_run";
    run(8);

    cur_tag = "high0";
    safe_write(1, 10, 0);
    run_to_wrap(1);
    H[1] = 0;
    run(20);

    cur_tag = "high12";
    safe_write(1, 10, 12);
    run_to_wrap(1);
    H[1] = 12;
    run(20);

    cur_tag = "last_wins";
    safe_write(1, 10, 2);
    write(1, 10, 6, 1'b1);
    run_to_wrap(1);
    H[1] = 6;
    run(20);

    cur_tag = "wrap_wr";
    run_to_wrap(1);
    write(1, 10, 1, 1'b1);
    run_to_wrap(1);
    H[1] = 1;
    run(20);

    cur_tag = "async_rst";
    run_to_wrap(0);
    run(2);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({out, ps} !== '0) begin
      failures++;
      $display("FAIL async_rst: got out=%b ps=%b, want out=000 ps=000", out, ps);
    end
    model_reset();
    cur_tag = "in_rst";
    step();
    reset = 1'b1;
    cur_tag = "post_rst";
    run(16);

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_square_wave_gen.md
# multi_square_wave_gen

Parametrised N-channel square-wave/PWM generator, successor to the fixed two-output square-wave block. Each channel has its own runtime-programmable period and high time, with glitch-free shadow updates applied only at period boundaries. It sits between the system clock domain and the waveform pins/consumers, programmed by a simple single-cycle write port.

## Interface

- N_CH, 2, number of independent output channels (1..16)
- CNT_W, 16, width of period/high-time counters
- DEF_PERIOD, 8, per-channel period after reset, in clk cycles (≥2, < 2^CNT_W)
- DEF_HIGH, 4, per-channel high time after reset, in clk cycles
- CH_W, max(1, clog2(N_CH)), derived; channel index width

- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-low reset
- en  in  N_CH  per-channel run enable
- cfg_we  in  1  config write strobe, single cycle
- cfg_ch  in  CH_W  channel addressed by write
- cfg_period  in  CNT_W  new period (cycles)
- cfg_high  in  CNT_W  new high time (cycles)
- cfg_ack  out  1  one-cycle pulse, write accepted
- cfg_err  out  1  one-cycle pulse, write rejected
- out  out  N_CH  waveform outputs, registered
- period_start  out  N_CH  one-cycle pulse on first cycle of each period

## Operation

- Per channel: counter cnt, active regs (act_period, act_high), pending regs (pend_period, pend_high), pend_valid flag.
- Reset (reset=0): cnt=DEF_PERIOD-1, act/pend = DEF_PERIOD/DEF_HIGH, pend_valid=0, out=0, period_start=0, cfg_ack=0, cfg_err=0. Asynchronous, takes effect mid-period.
- en[i]=0: cnt[i] held at act_period-1, out[i]=0, period_start[i]=0; if pend_valid, pending copied to active immediately and cnt loaded with new period-1.
- en[i]=1, each edge: if cnt==act_period-1 (wrap): cnt<=0, period_start<=1, pending (if valid) copied to active, pend_valid<=0; else cnt<=cnt+1, period_start<=0.
- out[i] registered together with cnt: out <= (cnt_next < act_high_next). First enabled edge therefore wraps to 0 and drives out high; high exactly act_high cycles per act_period.
- act_high=0: out constant 0. act_high ≥ act_period: out constant 1. period_start still pulses.
- Config write: cfg_we with cfg_period ≥ 2 and cfg_ch < N_CH: pend regs <= inputs, pend_valid<=1, cfg_ack pulses next cycle. Otherwise nothing stored, cfg_err pulses next cycle.
- Multiple writes before a wrap: last write wins. Write on the same edge as a wrap: the wrap uses pending value held before that edge; new write applies at the following wrap.
- Arithmetic unsigned, CNT_W bits; cnt never exceeds act_period-1.

## Timing

- cfg_ack/cfg_err: 1-cycle latency after cfg_we edge, never both high.
- Write → waveform change: at next wrap edge of that channel (≤ act_period cycles), or 1 edge if en[i]=0.
- en rise → out high and period_start on first rising edge with en=1.
- en fall → out low on next edge; partial period discarded.
- Reset release: first edge with en=1 starts a full period.

## Structure

- Package sqw_pkg: DEF_PERIOD/DEF_HIGH defaults, MIN_PERIOD=2, channel config struct (period, high).
- Sub-module sqw_channel: one counter, active/pending regs, out/period_start logic; top generates N_CH instances and decodes the write port and cfg_ack/cfg_err.

## Test plan

- Reset release, en=2'b11, defaults → each out 4 high/4 low, period_start every 8 cycles, both channels in phase.
- Write ch1 period=10 high=3 mid-period → cfg_ack pulse; ch1 finishes current 8-cycle period, then 3 high/7 low; ch0 unchanged.
- Write period=1 or cfg_ch ≥ N_CH → cfg_err pulse, no waveform change.
- high=0 then high=12 with period=10 → out constant 0, then constant 1; period_start still every 10 cycles.
- Two writes before wrap (high=2 then high=6) → only high=6 applied; write on wrap edge → deferred one period.
- reset low mid-high-phase → out=0 immediately (async); after release with en=1, full default period from cnt=0.
